// File: rtl/joypad_port.sv
// Two NES controller emulators: 4021-style latch/shift registers per pad,
// fed from host button bytes, with optional turbo on A/B from a ce-based timebase.
module joypad_port #(
  parameter int unsigned TURBO_PERIOD = 178684,
  parameter logic        FILL_BIT     = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       joypad_strobe,
  input  logic [1:0] joypad_clock,
  input  logic [7:0] buttons0,
  input  logic [7:0] buttons1,
  input  logic [1:0] turbo_a,
  input  logic [1:0] turbo_b,
  output logic [1:0] joypad_data,
  output logic [3:0] read_count0,
  output logic [3:0] read_count1
);

  localparam logic [17:0] TURBO_LAST = 18'(TURBO_PERIOD - 1);

  logic [7:0]  shift0_q, shift0_d;
  logic [7:0]  shift1_q, shift1_d;
  logic [3:0]  cnt0_q, cnt0_d;
  logic [3:0]  cnt1_q, cnt1_d;
  logic [1:0]  clk_hist_q;
  logic [17:0] tcnt_q, tcnt_d;
  logic        tphase_q, tphase_d;

  logic [7:0]  eff0, eff1;
  logic [1:0]  fall;

  always_comb begin
    eff0    = buttons0;
    eff0[0] = buttons0[0] | (turbo_a[0] & tphase_q);
    eff0[1] = buttons0[1] | (turbo_b[0] & tphase_q);
    eff1    = buttons1;
    eff1[0] = buttons1[0] | (turbo_a[1] & tphase_q);
    eff1[1] = buttons1[1] | (turbo_b[1] & tphase_q);
    fall    = clk_hist_q & ~joypad_clock;
  end

  // Latch has priority over a coincident falling edge; pads shift independently.
  always_comb begin
    shift0_d = shift0_q;
    shift1_d = shift1_q;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;
    if (joypad_strobe) begin
      shift0_d = eff0;
      shift1_d = eff1;
      cnt0_d   = '0;
      cnt1_d   = '0;
    end else begin
      if (fall[0]) begin
        shift0_d = {FILL_BIT, shift0_q[7:1]};
        cnt0_d   = (cnt0_q == 4'd8) ? 4'd8 : cnt0_q + 4'd1;
      end
      if (fall[1]) begin
        shift1_d = {FILL_BIT, shift1_q[7:1]};
        cnt1_d   = (cnt1_q == 4'd8) ? 4'd8 : cnt1_q + 4'd1;
      end
    end
  end

  always_comb begin
    tcnt_d   = tcnt_q;
    tphase_d = tphase_q;
    if (ce) begin
      if (tcnt_q == TURBO_LAST) begin
        tcnt_d   = '0;
        tphase_d = ~tphase_q;
      end else begin
        tcnt_d = tcnt_q + 18'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shift0_q   <= '0;
      shift1_q   <= '0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
      clk_hist_q <= '0;
      tcnt_q     <= '0;
      tphase_q   <= 1'b0;
    end else begin
      shift0_q   <= shift0_d;
      shift1_q   <= shift1_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
      clk_hist_q <= joypad_clock;
      tcnt_q     <= tcnt_d;
      tphase_q   <= tphase_d;
    end
  end

  assign joypad_data = {shift1_q[0], shift0_q[0]};
  assign read_count0 = cnt0_q;
  assign read_count1 = cnt1_q;

endmodule

// File: tb/tb_joypad_port.sv
// Directed bench for joypad_port: per-cycle vector table plus hand-written
// multi-cycle sequences (basic read, overrun, strobe priority, turbo, reset mid-read).
module tb_joypad_port;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ce;
  logic       joypad_strobe;
  logic [1:0] joypad_clock;
  logic [7:0] buttons0, buttons1;
  logic [1:0] turbo_a, turbo_b;
  logic [1:0] joypad_data;
  logic [3:0] read_count0, read_count1;

  int total = 0;
  int bad   = 0;

  joypad_port #(.TURBO_PERIOD(4), .FILL_BIT(1'b1)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ce            (ce),
    .joypad_strobe (joypad_strobe),
    .joypad_clock  (joypad_clock),
    .buttons0      (buttons0),
    .buttons1      (buttons1),
    .turbo_a       (turbo_a),
    .turbo_b       (turbo_b),
    .joypad_data   (joypad_data),
    .read_count0   (read_count0),
    .read_count1   (read_count1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic [1:0] jc;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [1:0] ed;
    logic [3:0] ec0;
    logic [3:0] ec1;
  } vec_t;

  vec_t tbl[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  logic [7:0] pat;
  logic       exp_ph;

  initial begin
    reset_n = 1'b0; ce = 1'b0; joypad_strobe = 1'b0; joypad_clock = 2'b00;
    buttons0 = '0; buttons1 = '0; turbo_a = '0; turbo_b = '0;

    tbl[0] = '{1'b1, 2'b00, 8'hA5, 8'h3C, 2'b01, 4'd0, 4'd0};
    tbl[1] = '{1'b0, 2'b00, 8'h00, 8'h00, 2'b01, 4'd0, 4'd0};
    tbl[2] = '{1'b0, 2'b01, 8'h00, 8'h00, 2'b01, 4'd0, 4'd0};
    tbl[3] = '{1'b0, 2'b00, 8'h00, 8'h00, 2'b00, 4'd1, 4'd0};
    tbl[4] = '{1'b0, 2'b11, 8'h00, 8'h00, 2'b00, 4'd1, 4'd0};
    tbl[5] = '{1'b0, 2'b00, 8'h00, 8'h00, 2'b01, 4'd2, 4'd1};
    tbl[6] = '{1'b1, 2'b01, 8'h02, 8'hFF, 2'b10, 4'd0, 4'd0};
    tbl[7] = '{1'b0, 2'b00, 8'h02, 8'hFF, 2'b11, 4'd1, 4'd0};
    tbl[8] = '{1'b0, 2'b10, 8'h02, 8'hFF, 2'b11, 4'd1, 4'd0};
    tbl[9] = '{1'b0, 2'b00, 8'h02, 8'hFF, 2'b11, 4'd1, 4'd1};

    // Reset state
    tick();
    tick();
    check("reset_data", {6'd0, joypad_data}, 8'h00);
    check("reset_rc0", {4'd0, read_count0}, 8'h00);
    check("reset_rc1", {4'd0, read_count1}, 8'h00);
    reset_n = 1'b1;

    // Vector table, one clk per row
    for (int i = 0; i < 10; i++) begin
      joypad_strobe = tbl[i].st;
      joypad_clock  = tbl[i].jc;
      buttons0      = tbl[i].b0;
      buttons1      = tbl[i].b1;
      tick();
      check($sformatf("vec%0d_data", i), {6'd0, joypad_data}, {6'd0, tbl[i].ed});
      check($sformatf("vec%0d_rc0", i), {4'd0, read_count0}, {4'd0, tbl[i].ec0});
      check($sformatf("vec%0d_rc1", i), {4'd0, read_count1}, {4'd0, tbl[i].ec1});
    end

    // Basic read: 4-clk high / 4-clk low pulses, then overrun
    joypad_clock = 2'b00;
    buttons0 = 8'b1010_0101;
    pat = 8'b1010_0101;
    joypad_strobe = 1'b1;
    repeat (3) tick();
    joypad_strobe = 1'b0;
    buttons0 = 8'h00;
    tick();
    for (int k = 0; k < 10; k++) begin
      joypad_clock = 2'b01;
      tick();
      tick();
      check($sformatf("read_bit%0d", k), {7'd0, joypad_data[0]}, {7'd0, (k < 8) ? pat[k] : 1'b1});
      tick();
      tick();
      joypad_clock = 2'b00;
      repeat (4) tick();
      if (k == 7) check("read_rc0_8", {4'd0, read_count0}, 8'd8);
    end
    check("overrun_rc0", {4'd0, read_count0}, 8'd8);

    // Strobe priority over a coincident falling edge
    buttons0 = 8'h02;
    joypad_clock = 2'b01;
    tick();
    joypad_strobe = 1'b1;
    joypad_clock = 2'b00;
    tick();
    check("prio_data_A", {7'd0, joypad_data[0]}, 8'd0);
    check("prio_rc0", {4'd0, read_count0}, 8'd0);
    joypad_strobe = 1'b0;
    tick();
    check("prio_noshift", {7'd0, joypad_data[0]}, 8'd0);
    joypad_clock = 2'b01;
    tick();
    joypad_clock = 2'b00;
    tick();
    check("prio_data_B", {7'd0, joypad_data[0]}, 8'd1);
    check("prio_rc0_1", {4'd0, read_count0}, 8'd1);

    // Independent pads
    buttons0 = 8'hFF;
    buttons1 = 8'h00;
    joypad_strobe = 1'b1;
    tick();
    joypad_strobe = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      joypad_clock = 2'b10;
      tick();
      tick();
      check($sformatf("indep_hi%0d", k), {6'd0, joypad_data}, 8'b01);
      joypad_clock = 2'b00;
      tick();
      tick();
      check($sformatf("indep_lo%0d", k), {6'd0, joypad_data}, 8'b01);
    end
    check("indep_rc0", {4'd0, read_count0}, 8'd0);
    check("indep_rc1", {4'd0, read_count1}, 8'd3);

    // Turbo A on pad 0, TURBO_PERIOD=4, ce every clk, latching every clk
    do_reset();
    buttons0 = 8'h00;
    buttons1 = 8'h00;
    turbo_a = 2'b01;
    joypad_strobe = 1'b1;
    ce = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      check($sformatf("turbo_k%0d", k), {7'd0, joypad_data[0]}, {7'd0, 1'(((k - 1) / 4) % 2)});
    end
    // 14 ce edges: counter=2, phase=1; freeze with ce=0
    ce = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("turbo_frozen%0d", k), {7'd0, joypad_data[0]}, 8'd1);
    end
    ce = 1'b1;
    tick();
    check("turbo_resume0", {7'd0, joypad_data[0]}, 8'd1);
    tick();
    check("turbo_resume1", {7'd0, joypad_data[0]}, 8'd1);
    tick();
    check("turbo_resume2", {7'd0, joypad_data[0]}, 8'd0);
    // Phase now 0; latched register must ignore later phase changes
    exp_ph = 1'b0;
    joypad_strobe = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("turbo_held%0d", k), {7'd0, joypad_data[0]}, {7'd0, exp_ph});
    end
    ce = 1'b0;
    turbo_a = 2'b00;

    // Reset mid-read with pad0 clock held high
    buttons0 = 8'hFF;
    joypad_strobe = 1'b1;
    tick();
    joypad_strobe = 1'b0;
    joypad_clock = 2'b01;
    tick();
    check("midread_pre", {7'd0, joypad_data[0]}, 8'd1);
    do_reset();
    tick();
    check("postrst_data", {6'd0, joypad_data}, 8'h00);
    check("postrst_rc0", {4'd0, read_count0}, 8'd0);
    joypad_clock = 2'b00;
    tick();
    check("postrst_read_data", {6'd0, joypad_data}, 8'h00);
    check("postrst_read_rc0", {4'd0, read_count0}, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
